// File: rtl/timer_irq_ctrl.sv
// Memory-mapped machine-timer controller: prescaled up-counter, compare, periodic/one-shot, sticky IRQ.
// Optional miss counter at index 5 is compiled in with TIMER_MISS_CNT_EN.
module timer_irq_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_COMPARE = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic        irq_ack,
  output logic        timer_irq,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PRE    = 3'd1;
  localparam logic [2:0] A_COUNT  = 3'd2;
  localparam logic [2:0] A_CMP    = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_MISS   = 3'd5;

  state_e             state_q, state_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   prescale_q, prescale_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   compare_q, compare_d;
  logic [CNT_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic               pending_q, pending_d;
  logic               timer_irq_q, timer_irq_d;
  logic [31:0]        bus_rdata_q, bus_rdata_d;
  logic               bus_ready_q, bus_ready_d;

  logic wr_en, wr_ctrl, wr_pre, wr_count, wr_cmp, wr_status;
  logic tick, expiry;
  logic [31:0] miss_rd;

  always_comb begin
    wr_en     = bus_req & bus_we;
    wr_ctrl   = wr_en && (bus_addr == A_CTRL);
    wr_pre    = wr_en && (bus_addr == A_PRE);
    wr_count  = wr_en && (bus_addr == A_COUNT);
    wr_cmp    = wr_en && (bus_addr == A_CMP);
    wr_status = wr_en && (bus_addr == A_STATUS);
    tick      = (state_q == ST_RUN) && (pre_cnt_q == prescale_q);
    expiry    = tick && (count_q == compare_q);
  end

`ifdef TIMER_MISS_CNT_EN
  logic [7:0] miss_q, miss_d;
  logic       wr_miss;

  always_comb begin
    wr_miss = wr_en && (bus_addr == A_MISS);
    miss_d  = miss_q;
    if (wr_miss) begin
      miss_d = '0;
    end else if (expiry && pending_q && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end
    miss_rd = {24'b0, miss_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) miss_q <= '0;
    else     miss_q <= miss_d;
  end
`else
  assign miss_rd = '0;
`endif

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    count_d     = count_q;
    compare_d   = compare_q;
    pre_cnt_d   = pre_cnt_q;
    pending_d   = pending_q;
    timer_irq_d = pending_q & ctrl_q[2];
    bus_ready_d = bus_req;
    bus_rdata_d = '0;

    if (state_q == ST_RUN) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    end
    if (tick && !expiry) begin
      count_d = count_q + 1'b1;
    end
    if (expiry) begin
      if (ctrl_q[1]) begin
        count_d = '0;
      end else begin
        ctrl_d[0] = 1'b0;
        state_d   = ST_DONE;
      end
    end

    // Software writes are applied after the timer update so they take priority
    // over same-cycle counter/state changes; pending still honours the expiry.
    if (wr_ctrl) begin
      ctrl_d = bus_wdata[2:0];
      if (bus_wdata[0]) begin
        state_d = ST_RUN;
        if (state_q != ST_RUN) begin
          count_d   = '0;
          pre_cnt_d = '0;
        end
      end else begin
        state_d   = ST_IDLE;
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
      end
    end
    if (wr_pre)   prescale_d = CNT_W'(bus_wdata);
    if (wr_count) count_d    = CNT_W'(bus_wdata);
    if (wr_cmp)   compare_d  = CNT_W'(bus_wdata);

    if (irq_ack || (wr_status && bus_wdata[0])) pending_d = 1'b0;
    if (expiry)                                 pending_d = 1'b1;

    if (bus_req && !bus_we) begin
      case (bus_addr)
        A_CTRL:   bus_rdata_d = 32'(ctrl_q);
        A_PRE:    bus_rdata_d = 32'(prescale_q);
        A_COUNT:  bus_rdata_d = 32'(count_q);
        A_CMP:    bus_rdata_d = 32'(compare_q);
        A_STATUS: bus_rdata_d = {31'b0, pending_q};
        A_MISS:   bus_rdata_d = miss_rd;
        default:  bus_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      prescale_q  <= '0;
      count_q     <= '0;
      compare_q   <= CNT_W'(RST_COMPARE);
      pre_cnt_q   <= '0;
      pending_q   <= 1'b0;
      timer_irq_q <= 1'b0;
      bus_rdata_q <= '0;
      bus_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      pre_cnt_q   <= pre_cnt_d;
      pending_q   <= pending_d;
      timer_irq_q <= timer_irq_d;
      bus_rdata_q <= bus_rdata_d;
      bus_ready_q <= bus_ready_d;
    end
  end

  assign bus_rdata = bus_rdata_q;
  assign bus_ready = bus_ready_q;
  assign timer_irq = timer_irq_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed + randomized bench for timer_irq_ctrl; expected values come from
// closed-form timing arithmetic ((COMPARE+1)*(PRESCALE+1) periods).
`timescale 1ns/1ps
module tb_timer_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req, bus_we, irq_ack;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready, timer_irq;
  logic [1:0]  state_o;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  logic [31:0] rd_val;
  time         last_edge, t_en, t1, t2;
  bit          ok;

  timer_irq_ctrl #(.CNT_W(32), .RST_COMPARE(100)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .irq_ack(irq_ack), .timer_irq(timer_irq), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_op(input logic we, input logic [2:0] a, input logic [31:0] d, input logic ack);
    @(negedge clk);
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d; irq_ack = ack;
    @(posedge clk);
    last_edge = $time;
    #1;
    bus_req = 1'b0; bus_we = 1'b0; irq_ack = 1'b0;
    check("bus_ready", 32'(bus_ready), 32'd1);
    rd_val = bus_rdata;
    if (we) check("wr_rdata_zero", bus_rdata, 32'd0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    if (n != 0) #1;
  endtask

  task automatic wait_irq(input logic lvl, input int unsigned bound, output time t, output bit found);
    found = 1'b0;
    t = 0;
    for (int unsigned i = 0; i < bound; i++) begin
      if (timer_irq === lvl) begin
        found = 1'b1;
        t = $time;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int unsigned p, c, per, tt, m, exp_v;
    logic [31:0] rst_exp [8];
    rst_exp = '{32'd0, 32'd0, 32'd0, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0};
    rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; irq_ack = 1'b0; bus_addr = '0; bus_wdata = '0;
    #12 rst = 1'b0;
    check("rst_irq", 32'(timer_irq), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_ready", 32'(bus_ready), 32'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      bus_op(1'b0, 3'(i), 32'd0, 1'b0);
      check($sformatf("rst_read_%0d", i), rd_val, rst_exp[i]);
    end
    idle(1);
    check("ready_pulse_drops", 32'(bus_ready), 32'd0);

    // periodic, PRESCALE=0, COMPARE=9: period 10 cycles between acked interrupts
    bus_op(1'b1, 3'd1, 32'd0, 1'b0);
    bus_op(1'b1, 3'd3, 32'd9, 1'b0);
    bus_op(1'b1, 3'd0, 32'd7, 1'b0);
    wait_irq(1'b1, 40, t1, ok);
    check("per_first_irq_seen", 32'(ok), 32'd1);
    for (int unsigned r = 0; r < 3; r++) begin
      @(negedge clk); irq_ack = 1'b1;
      @(posedge clk); #1; irq_ack = 1'b0;
      wait_irq(1'b0, 5, t2, ok);
      check("per_ack_clears", 32'(ok), 32'd1);
      wait_irq(1'b1, 20, t2, ok);
      check("per_irq_again", 32'(ok), 32'd1);
      check("per_period", 32'((t2 - t1) / 10), 32'd10);
      check("per_state_run", 32'(state_o), 32'd1);
      t1 = t2;
    end
    bus_op(1'b1, 3'd0, 32'd0, 1'b0);
    bus_op(1'b1, 3'd4, 32'd1, 1'b0);

    // one-shot, PRESCALE=3, COMPARE=4: pending 20 cycles after enable
    bus_op(1'b1, 3'd1, 32'd3, 1'b0);
    bus_op(1'b1, 3'd3, 32'd4, 1'b0);
    bus_op(1'b1, 3'd0, 32'd5, 1'b0);
    t_en = last_edge;
    idle(19);
    bus_op(1'b0, 3'd4, 32'd0, 1'b0);
    check("os_not_yet", rd_val, 32'd0);
    bus_op(1'b0, 3'd4, 32'd0, 1'b0);
    check("os_pending_at_20", rd_val, 32'd1);
    bus_op(1'b0, 3'd0, 32'd0, 1'b0);
    check("os_ctrl_cleared_en", rd_val, 32'd4);
    bus_op(1'b0, 3'd2, 32'd0, 1'b0);
    check("os_count_hold", rd_val, 32'd4);
    check("os_state_done", 32'(state_o), 32'd2);
    check("os_irq", 32'(timer_irq), 32'd1);
    idle(10);
    bus_op(1'b0, 3'd2, 32'd0, 1'b0);
    check("os_count_still", rd_val, 32'd4);
    bus_op(1'b1, 3'd4, 32'd1, 1'b0);

    // expiry coincident with irq_ack and STATUS W1C: set wins
    bus_op(1'b1, 3'd1, 32'd0, 1'b0);
    bus_op(1'b1, 3'd3, 32'd4, 1'b0);
    bus_op(1'b1, 3'd0, 32'd7, 1'b0);
    t_en = last_edge;
    idle(6);
    bus_op(1'b1, 3'd4, 32'd1, 1'b0);
    bus_op(1'b0, 3'd4, 32'd0, 1'b0);
    check("w1c_cleared", rd_val, 32'd0);
    idle(1);
    bus_op(1'b1, 3'd4, 32'd1, 1'b1);
    check("coinc_edge", 32'((last_edge - t_en) / 10), 32'd10);
    bus_op(1'b0, 3'd4, 32'd0, 1'b0);
    check("coinc_pending", rd_val, 32'd1);
    check("coinc_irq", 32'(timer_irq), 32'd1);

    // asynchronous reset while running with pending set
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("arst_irq", 32'(timer_irq), 32'd0);
    check("arst_state", 32'(state_o), 32'd0);
    #1 rst = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      bus_op(1'b0, 3'(i), 32'd0, 1'b0);
      check($sformatf("arst_read_%0d", i), rd_val, rst_exp[i]);
    end

    // COMPARE moved below COUNT: no expiry until wrap; COUNT write beats tick
    bus_op(1'b1, 3'd0, 32'd3, 1'b0);
    t_en = last_edge;
    idle(19);
    bus_op(1'b1, 3'd3, 32'd3, 1'b0);
    idle(30);
    bus_op(1'b0, 3'd4, 32'd0, 1'b0);
    check("below_no_expiry", rd_val, 32'd0);
    bus_op(1'b0, 3'd2, 32'd0, 1'b0);
    check("below_count", rd_val, 32'((last_edge - t_en) / 10) - 32'd1);
    bus_op(1'b1, 3'd2, 32'd1000, 1'b0);
    bus_op(1'b0, 3'd2, 32'd0, 1'b0);
    check("count_wr_wins", rd_val, 32'd1000);
    bus_op(1'b0, 3'd2, 32'd0, 1'b0);
    check("count_resumes", rd_val, 32'd1001);
    bus_op(1'b1, 3'd0, 32'd0, 1'b0);

`ifdef TIMER_MISS_CNT_EN
    bus_op(1'b1, 3'd3, 32'd0, 1'b0);
    bus_op(1'b1, 3'd0, 32'd3, 1'b0);
    idle(310);
    bus_op(1'b0, 3'd5, 32'd0, 1'b0);
    check("miss_saturates", rd_val, 32'd255);
    bus_op(1'b1, 3'd5, 32'd0, 1'b0);
    bus_op(1'b0, 3'd5, 32'd0, 1'b0);
    check("miss_cleared", rd_val, 32'd0);
    bus_op(1'b1, 3'd0, 32'd0, 1'b0);
    bus_op(1'b1, 3'd4, 32'd1, 1'b0);
`else
    bus_op(1'b1, 3'd5, 32'd5, 1'b0);
    bus_op(1'b0, 3'd5, 32'd0, 1'b0);
    check("miss_absent", rd_val, 32'd0);
`endif

    // randomized configurations against closed-form timing model
    for (int unsigned trial = 0; trial < 8; trial++) begin
      p   = $urandom_range(0, 3);
      c   = $urandom_range(0, 6);
      per = $urandom_range(0, 1);
      tt  = (c + 1) * (p + 1);
      bus_op(1'b1, 3'd0, 32'd0, 1'b0);
      bus_op(1'b1, 3'd4, 32'd1, 1'b0);
      bus_op(1'b1, 3'd1, p, 1'b0);
      bus_op(1'b1, 3'd3, c, 1'b0);
      bus_op(1'b1, 3'd0, 32'd5 | (per << 1), 1'b0);
      t_en = last_edge;
      for (int unsigned j = 0; j < 10; j++) begin
        idle($urandom_range(0, 4));
        if ($urandom_range(0, 1) == 1) begin
          bus_op(1'b0, 3'd2, 32'd0, 1'b0);
          m = int'((last_edge - t_en) / 10) - 1;
          if (per == 1)     exp_v = (m % tt) / (p + 1);
          else if (m >= tt) exp_v = c;
          else              exp_v = m / (p + 1);
          check("rnd_count", rd_val, exp_v);
        end else begin
          bus_op(1'b0, 3'd4, 32'd0, 1'b0);
          m = int'((last_edge - t_en) / 10) - 1;
          check("rnd_status", rd_val, 32'(m >= tt));
        end
        check("rnd_irq", 32'(timer_irq), 32'(m >= tt));
        check("rnd_state", 32'(state_o), (per == 0 && m + 1 >= tt) ? 32'd2 : 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
Memory-mapped controller for the core's machine-timer resource: prescaled up-counter, compare register, periodic/one-shot sequencing, and a sticky interrupt-pending latch with acknowledge.
Sits between the load/store data bus (register access) and the CSR/trap unit (timer_irq out, irq_ack in).
Replaces the fixed-limit free-running interrupt source with a software-configurable one.

Parameters:
CNT_W, 32, width of COUNT, COMPARE, PRESCALE registers
RST_COMPARE, 100, reset value of COMPARE

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
bus_req  input  1  register access request, single-cycle strobe
bus_we  input  1  1=write, 0=read; valid with bus_req
bus_addr  input  3  word index: 0 CTRL, 1 PRESCALE, 2 COUNT, 3 COMPARE, 4 STATUS, 5 MISS
bus_wdata  input  32  write data
bus_rdata  output  32  read data, valid when bus_ready=1
bus_ready  output  1  one-cycle completion pulse
irq_ack  input  1  trap unit acknowledge, clears pending
timer_irq  output  1  level interrupt to trap unit
state_o  output  2  FSM state (debug): 0 IDLE, 1 RUN, 2 DONE

Behaviour:
- Reset values: CTRL=0 {bit0 enable, bit1 periodic, bit2 irq_en}; PRESCALE=0; COUNT=0; COMPARE=RST_COMPARE; pending=0; pre_cnt=0; bus_rdata=0; bus_ready=0; timer_irq=0; state=IDLE.
- Bus: every bus_req completes in exactly 1 cycle. bus_ready is registered high the cycle after bus_req. bus_rdata is registered the same cycle; it is 0 for writes and for unmapped addresses 6–7. Writes to unmapped addresses are ignored. Back-to-back requests are allowed.
- STATUS: bit0=pending, write-1-to-clear; other bits read 0. MISS reads 0 unless the optional feature is compiled in.
- Prescaler: in RUN, pre_cnt increments each clk. When pre_cnt==PRESCALE, a tick fires and pre_cnt returns to 0. PRESCALE=0 gives a tick every cycle.
- Tick: if COUNT==COMPARE, an expiry occurs; otherwise COUNT<=COUNT+1, wrapping modulo 2^CNT_W.
- Expiry: pending<=1.
  - Periodic: COUNT<=0; stay in RUN. Interrupt period is (COMPARE+1)*(PRESCALE+1) cycles.
  - One-shot: COUNT holds; CTRL.enable<=0; go to DONE.
- FSM:
  - IDLE->RUN on a CTRL write with enable=1; COUNT and pre_cnt clear on that write.
  - RUN->IDLE on a CTRL write with enable=0; COUNT holds.
  - RUN->DONE on one-shot expiry.
  - DONE->RUN on a CTRL write with enable=1 (COUNT and pre_cnt cleared).
  - DONE->IDLE on a CTRL write with enable=0.
- timer_irq = pending & CTRL.irq_en, registered (1 cycle after pending/irq_en change).
- Simultaneous events:
  - Expiry and irq_ack, or expiry and STATUS W1C, in the same cycle: set wins, pending=1.
  - A software write to COUNT in the same cycle as a tick: the write wins and no increment occurs that cycle. An expiry from a compare on the old value still sets pending.
  - A COMPARE write takes effect from the next tick.
- COMPARE below the current COUNT: no expiry until COUNT wraps through 2^CNT_W.
- Asynchronous reset mid-operation returns all state to reset values immediately; any pending interrupt is lost.

Optional Feature:
TIMER_MISS_CNT_EN.
- Defined: MISS is an 8-bit saturating counter (at 255). It increments on each expiry that occurs while pending is already 1. Any write to MISS clears it. Readable at index 5 in bits [7:0].
- Undefined: no MISS logic; index 5 reads 0 and writes are ignored.

Test Plan:
- Reset, then read all indices -> CTRL=0, PRESCALE=0, COUNT=0, COMPARE=100, STATUS=0, MISS=0; timer_irq=0; bus_ready pulses 1 cycle after each req.
- PRESCALE=0, COMPARE=9, CTRL=0b111 (periodic, irq) -> timer_irq rises every 10 cycles once acked; irq_ack each time clears it; state stays RUN.
- PRESCALE=3, COMPARE=4, CTRL=0b101 (one-shot) -> pending set 20 cycles after the enable write; state DONE; CTRL reads 0b100; COUNT reads 4 and holds.
- Expiry cycle coincident with irq_ack and STATUS W1C -> pending remains 1, timer_irq stays high.
- Compile with TIMER_MISS_CNT_EN; COMPARE=0, periodic, never ack for 300 expiries -> MISS reads 255; write MISS -> reads 0.
- Assert rst during RUN with pending=1 -> timer_irq=0 and state=IDLE within the same cycle; all registers at reset values.
